// File: rtl/sm_run_ctrl.sv
// -----------------------------------------------------------------------------
// sm_run_ctrl
//   Board-level run controller for the schoolMIPS core. Three raw active-low
//   push-buttons are synchronized and debounced into one-cycle press events.
//   These events drive a HALT / RUN / single-STEP controller, select the run
//   speed (clkDevide) and step the debug register address (regAddr).
//
// Ports
//   clk         board clock
//   rst_n       asynchronous active-low reset
//   key_mode_n  raw key: toggle RUN/HALT
//   key_step_n  raw key: single step in HALT, speed change in RUN
//   key_sel_n   raw key: next debug register
//   clkEnable   core clock enable (registered)
//   clkDevide   core clock divider select (registered)
//   regAddr     debug register address (registered)
//   run         high while in RUN
//   step_busy   high while in STEP
//
// State table
//   state  | meaning
//   S_HALT | core clock gated off, waiting for mode/step key
//   S_RUN  | core clock free-running, step key lowers clkDevide
//   S_STEP | core clock on for exactly one core clock period, keys ignored
// -----------------------------------------------------------------------------
module sm_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DIV_RESET       = 8,
  parameter int DIV_MIN         = 2,
  parameter int DIV_MAX         = 12,
  parameter int REG_RESET       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode_n,
  input  logic       key_step_n,
  input  logic       key_sel_n,
  output logic       clkEnable,
  output logic [3:0] clkDevide,
  output logic [4:0] regAddr,
  output logic       run,
  output logic       step_busy
);

  localparam int            CW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    DIV_RST_C = 4'(DIV_RESET);
  localparam logic [3:0]    DIV_MIN_C = 4'(DIV_MIN);
  localparam logic [3:0]    DIV_MAX_C = 4'(DIV_MAX);
  localparam logic [4:0]    REG_RST_C = 5'(REG_RESET);

  // Key vector bit order: [2]=mode, [1]=step, [0]=sel
  localparam int K_MODE = 2;
  localparam int K_STEP = 1;
  localparam int K_SEL  = 0;

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  logic [2:0]         keys_n;
  logic [2:0]         sync1_q;
  logic [2:0]         sync2_q;
  logic [2:0]         stable_q;
  logic [2:0]         ev_q;
  logic [2:0][CW-1:0] db_cnt_q;

  state_t             state_q;
  logic [16:0]        step_cnt_q;
  logic               clk_en_q;
  logic [3:0]         div_q;
  logic [4:0]         reg_q;
  logic               run_q;
  logic               step_busy_q;

  logic               mode_ev;
  logic               step_ev;
  logic               sel_ev;

  assign keys_n = {key_mode_n, key_step_n, key_sel_n};

  // Synchronizer + debouncer per key. The press event is raised together with
  // the stable level falling, so it is a clean single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      stable_q <= '1;
      ev_q     <= '0;
      db_cnt_q <= '0;
    end else begin
      sync1_q <= keys_n;
      sync2_q <= sync1_q;
      for (int k = 0; k < 3; k++) begin
        ev_q[k] <= 1'b0;
        if (sync2_q[k] == stable_q[k]) begin
          db_cnt_q[k] <= '0;
        end else if (db_cnt_q[k] == DB_LAST) begin
          stable_q[k] <= sync2_q[k];
          db_cnt_q[k] <= '0;
          // stable was 1 and differs from synced, so this is a press
          ev_q[k]     <= stable_q[k];
        end else begin
          db_cnt_q[k] <= db_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  assign mode_ev = ev_q[K_MODE];
  assign step_ev = ev_q[K_STEP];
  assign sel_ev  = ev_q[K_SEL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HALT;
      step_cnt_q  <= '0;
      clk_en_q    <= 1'b0;
      div_q       <= DIV_RST_C;
      run_q       <= 1'b0;
      step_busy_q <= 1'b0;
    end else begin
      case (state_q)
        S_HALT: begin
          if (mode_ev) begin
            state_q  <= S_RUN;
            clk_en_q <= 1'b1;
            run_q    <= 1'b1;
          end else if (step_ev) begin
            state_q     <= S_STEP;
            clk_en_q    <= 1'b1;
            step_busy_q <= 1'b1;
            // One core clock period is 2^(clkDevide+1) input cycles
            step_cnt_q  <= (17'd1 << ({1'b0, div_q} + 5'd1)) - 17'd1;
          end
        end
        S_RUN: begin
          if (mode_ev) begin
            state_q  <= S_HALT;
            clk_en_q <= 1'b0;
            run_q    <= 1'b0;
          end else if (step_ev) begin
            div_q <= (div_q == DIV_MIN_C) ? DIV_MAX_C : div_q - 4'd1;
          end
        end
        S_STEP: begin
          if (step_cnt_q == 17'd0) begin
            state_q     <= S_HALT;
            clk_en_q    <= 1'b0;
            step_busy_q <= 1'b0;
          end else begin
            step_cnt_q <= step_cnt_q - 17'd1;
          end
        end
        default: begin
          state_q     <= S_HALT;
          clk_en_q    <= 1'b0;
          run_q       <= 1'b0;
          step_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Register browsing runs regardless of the controller state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q <= REG_RST_C;
    end else if (sel_ev) begin
      reg_q <= reg_q + 5'd1;
    end
  end

  assign clkEnable = clk_en_q;
  assign clkDevide = div_q;
  assign regAddr   = reg_q;
  assign run       = run_q;
  assign step_busy = step_busy_q;

endmodule
